id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Pipeline register between decode (register-file read) and execute.
- Captures the two register-file read operands, immediate, destination address and decode control each cycle.
- Patches operands with same-cycle write-back data, so no stale read is captured when write-back hits the register being read.
- Detects load-use hazards, stalls upstream and inserts a bubble.
- Supports flush (taken branch) and hold (downstream stall), and counts inserted bubbles.

Parameters:
DATA_W, 32, operand/immediate width
ADDR_W, 5, register address width
ALUOP_W, 2, ALU operation code width
CNT_W, 16, bubble counter width (saturating)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  decode stage holds a real instruction
RSaddr_i  in  ADDR_W  source 1 address
RTaddr_i  in  ADDR_W  source 2 address
uses_rt_i  in  1  instruction reads RT (R-type/store/branch)
RDaddr_i  in  ADDR_W  destination address
RSdata_i  in  DATA_W  register-file RS read data
RTdata_i  in  DATA_W  register-file RT read data
imm_i  in  DATA_W  sign-extended immediate
RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i  in  1 each  decode control
ALUOp_i  in  ALUOP_W  ALU op
WBaddr_i  in  ADDR_W  write-back address (same bus driven into the register file)
WBdata_i  in  DATA_W  write-back data
WBwrite_i  in  1  write-back enable
flush_i  in  1  squash the instruction entering EX
hold_i  in  1  freeze EX register (downstream stall)
hazard_stall_o  out  1  combinational; freeze PC and IF/ID
valid_o  out  1  EX holds a real instruction
RSdata_o, RTdata_o, imm_o  out  DATA_W  registered operands
RSaddr_o, RTaddr_o, RDaddr_o  out  ADDR_W  registered addresses (for forwarding unit)
RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o  out  1 each  registered control
ALUOp_o  out  ALUOP_W  registered ALU op
bubble_cnt_o  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset (async, rst_i=1): all registered outputs 0, valid_o=0, bubble_cnt_o=0. Asserting mid-operation clears immediately, no clock needed. First capture occurs on the first rising edge after deassertion.
- Load-use hazard (combinational) is asserted when all of the following hold:
  - valid_o & MemRead_o & (RDaddr_o != 0) & valid_i;
  - RDaddr_o == RSaddr_i, or (uses_rt_i & RDaddr_o == RTaddr_i).
- hazard_stall_o = load-use hazard & ~flush_i & ~hold_i.
- Bypass on capture:
  - RS value = WBdata_i if WBwrite_i & WBaddr_i!=0 & WBaddr_i==RSaddr_i, else RSdata_i. RT likewise.
  - Address 0 always captures 0.
- Per rising edge, priority order (highest first):
  1. flush_i: load bubble.
  2. hold_i: all registers keep their value; counter unchanged.
  3. hazard: load bubble; bubble_cnt_o += 1, saturating at all-ones.
  4. Otherwise: capture inputs; valid_o=valid_i.
- Bubble: valid_o=0 and all six control outputs = 0. Data/address outputs may hold any value; the bench checks only valid/control.
- If valid_i=0 on a capture, control outputs are still forced to 0.
- Latency: one cycle from decode to EX outputs. A stalled instruction re-presents the next cycle, by which point the load has left EX, so the hazard clears; exactly one bubble per load-use.
- flush_i and hazard in the same cycle: flush wins, no count, no stall.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, ADDR_W and ALUOP_W constants;
  - struct ctrl_t {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp};
  - constant CTRL_BUBBLE (all zero).
- One natural combinational sub-module, hazard_detect: load-use compare producing the raw hazard bit. Bypass muxes and pipeline register stay in id_ex_stage.

Test Plan:
- Reset mid-stream:
  - stimulus: capture valid instr with RegWrite_i=1, then pulse rst_i between edges;
  - response: valid_o=0, RegWrite_o=0, bubble_cnt_o=0 immediately, before any edge.
- Load-use:
  - stimulus: EX holds lw RD=8; decode presents add RS=8;
  - response: hazard_stall_o=1; next edge valid_o=0, controls 0, bubble_cnt_o=1; following edge add captured, valid_o=1.
- RT hazard gating:
  - stimulus: EX holds lw RD=9; decode RT=9 with uses_rt_i=0;
  - response: hazard_stall_o=0, captured normally. With uses_rt_i=1, stall.
- Write-back bypass:
  - stimulus: RSaddr_i=5, RSdata_i=0x1111, WBwrite_i=1, WBaddr_i=5, WBdata_i=0xABCD;
  - response: RSdata_o=0xABCD.
  - stimulus: same with WBaddr_i=0 and RSaddr_i=0;
  - response: RSdata_o=0.
- Priority:
  - stimulus: hazard + hold_i=1;
  - response: outputs frozen, hazard_stall_o=0, counter unchanged.
  - stimulus: hazard + flush_i=1;
  - response: bubble, counter unchanged.
- Saturation:
  - stimulus: CNT_W=2, five consecutive load-use bubbles;
  - response: bubble_cnt_o sticks at 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared pipeline definitions for the decode/execute boundary.
//   DATA_W      operand / immediate width
//   ADDR_W      register address width
//   ALUOP_W     ALU operation code width
//   ctrl_t      decode control bundle carried into EX
//   CTRL_BUBBLE control value of an inserted bubble (no side effects)
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Raw load-use hazard compare between the instruction sitting in EX and the
// instruction currently in decode. Purely combinational; flush/hold gating
// is applied by the caller.
//   ex_valid_i    EX holds a real instruction
//   ex_memread_i  EX instruction is a load
//   ex_rd_i       EX destination address
//   id_valid_i    decode holds a real instruction
//   id_rs_i       decode source 1 address
//   id_rt_i       decode source 2 address
//   id_uses_rt_i  decode instruction actually reads source 2
//   hazard_o      load-use hazard
// ---------------------------------------------------------------------------
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  output logic              hazard_o
);

  logic w_load_live;
  logic w_rs_match;
  logic w_rt_match;

  // A load into r0 never produces a value anyone waits for.
  assign w_load_live = ex_valid_i & ex_memread_i & (ex_rd_i != '0) & id_valid_i;
  assign w_rs_match  = (ex_rd_i == id_rs_i);
  // RT field of I-type instructions is a destination, so only count it when read.
  assign w_rt_match  = id_uses_rt_i & (ex_rd_i == id_rt_i);
  assign hazard_o    = w_load_live & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with write-back bypass, load-use stall/bubble
// insertion, flush, hold and a saturating bubble counter.
//   clk_i, rst_i              clock / async active-high reset
//   valid_i, *addr_i, *data_i decode-stage instruction and register reads
//   *_i control               decode control bits
//   WB*_i                     write-back bus (also feeding the register file)
//   flush_i, hold_i           squash entering instruction / freeze EX
//   hazard_stall_o            freeze PC and IF/ID this cycle
//   *_o                       registered EX-stage instruction
//   bubble_cnt_o              load-use bubbles inserted (saturating)
// ---------------------------------------------------------------------------
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int ALUOP_W = cpu_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [ADDR_W-1:0]  RSaddr_i,
  input  logic [ADDR_W-1:0]  RTaddr_i,
  input  logic               uses_rt_i,
  input  logic [ADDR_W-1:0]  RDaddr_i,
  input  logic [DATA_W-1:0]  RSdata_i,
  input  logic [DATA_W-1:0]  RTdata_i,
  input  logic [DATA_W-1:0]  imm_i,
  input  logic               RegWrite_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               MemtoReg_i,
  input  logic               ALUSrc_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [ADDR_W-1:0]  WBaddr_i,
  input  logic [DATA_W-1:0]  WBdata_i,
  input  logic               WBwrite_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               hazard_stall_o,
  output logic               valid_o,
  output logic [DATA_W-1:0]  RSdata_o,
  output logic [DATA_W-1:0]  RTdata_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [ADDR_W-1:0]  RSaddr_o,
  output logic [ADDR_W-1:0]  RTaddr_o,
  output logic [ADDR_W-1:0]  RDaddr_o,
  output logic               RegWrite_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic               ALUSrc_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_rs_addr;
  logic [ADDR_W-1:0] r_rt_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_hazard;
  logic              w_stall;
  ctrl_t             w_ctrl_in;
  logic [DATA_W-1:0] w_rs_byp;
  logic [DATA_W-1:0] w_rt_byp;

  hazard_detect #(
    .ADDR_W (ADDR_W)
  ) u_hazard_detect (
    .ex_valid_i   (r_valid),
    .ex_memread_i (r_ctrl.MemRead),
    .ex_rd_i      (r_rd_addr),
    .id_valid_i   (valid_i),
    .id_rs_i      (RSaddr_i),
    .id_rt_i      (RTaddr_i),
    .id_uses_rt_i (uses_rt_i),
    .hazard_o     (w_hazard)
  );

  // Flush and hold both take precedence over the hazard, so upstream must not stall.
  assign w_stall        = w_hazard & ~flush_i & ~hold_i;
  assign hazard_stall_o = w_stall;

  assign w_ctrl_in = '{RegWrite: RegWrite_i, MemRead: MemRead_i, MemWrite: MemWrite_i,
                       MemtoReg: MemtoReg_i, ALUSrc: ALUSrc_i, ALUOp: ALUOp_i};

  // The register file writes on the same edge we capture, so its read port
  // still shows the old value; steer the write-back data in instead.
  always_comb begin
    w_rs_byp = RSdata_i;
    w_rt_byp = RTdata_i;
    if (RSaddr_i == '0)
      w_rs_byp = '0;
    else if (WBwrite_i && (WBaddr_i == RSaddr_i))
      w_rs_byp = WBdata_i;
    if (RTaddr_i == '0)
      w_rt_byp = '0;
    else if (WBwrite_i && (WBaddr_i == RTaddr_i))
      w_rt_byp = WBdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_ctrl       <= CTRL_BUBBLE;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_rd_addr    <= '0;
      r_bubble_cnt <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
    end else if (hold_i) begin
      r_valid <= r_valid;
    end else if (w_stall) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      if (r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else begin
      r_valid   <= valid_i;
      r_ctrl    <= valid_i ? w_ctrl_in : CTRL_BUBBLE;
      r_rs_data <= w_rs_byp;
      r_rt_data <= w_rt_byp;
      r_imm     <= imm_i;
      r_rs_addr <= RSaddr_i;
      r_rt_addr <= RTaddr_i;
      r_rd_addr <= RDaddr_i;
    end
  end

  assign valid_o      = r_valid;
  assign RSdata_o     = r_rs_data;
  assign RTdata_o     = r_rt_data;
  assign imm_o        = r_imm;
  assign RSaddr_o     = r_rs_addr;
  assign RTaddr_o     = r_rt_addr;
  assign RDaddr_o     = r_rd_addr;
  assign RegWrite_o   = r_ctrl.RegWrite;
  assign MemRead_o    = r_ctrl.MemRead;
  assign MemWrite_o   = r_ctrl.MemWrite;
  assign MemtoReg_o   = r_ctrl.MemtoReg;
  assign ALUSrc_o     = r_ctrl.ALUSrc;
  assign ALUOp_o      = r_ctrl.ALUOp;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule
